// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
// Holds the clear-sequencer state encoding and default geometry.
package regfile_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 16;
    localparam int DEF_AW    = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: walks every entry once, zeroing one per enabled cycle.
// busy is high for the whole sweep; en=0 freezes the walk.
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int IW    = idx_width(DEF_DEPTH)
) (
    input  logic          clk_main,
    input  logic          reset,
    input  logic          en,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_we,
    output logic [IW-1:0] clr_idx
);

    localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

    clr_state_t    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;

    always_ff @(posedge clk_main or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy    = 1'b0;
        clr_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en && clr_req) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            end
            CLEAR: begin
                busy = 1'b1;
                if (en) begin
                    clr_we = 1'b1;
                    if (idx_q == LAST) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign clr_idx = idx_q;

endmodule

// File: rtl/regfile_mp.sv
// One-write / two-read register file with registered reads,
// write-first bypass and a sequenced full-array clear.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int AW      = DEF_AW,
    parameter int ZERO_R0 = 0
) (
    input  logic             clk_main,
    input  logic             reset,
    input  logic             en,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic             re,
    input  logic [AW-1:0]    ra_a,
    input  logic [AW-1:0]    ra_b,
    output logic [WIDTH-1:0] rd_a,
    output logic [WIDTH-1:0] rd_b,
    output logic             rd_valid,
    input  logic             clr_req,
    output logic             busy
);

    localparam int            IW      = idx_width(DEPTH);
    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
    localparam bit            Z0      = (ZERO_R0 != 0);

    logic [WIDTH-1:0] mem [DEPTH];

    logic          clr_we;
    logic [IW-1:0] clr_idx;
    logic          clr_acc;
    logic          wr_ok;
    logic          rd_acc;
    logic [WIDTH-1:0] nxt_a, nxt_b;

    regfile_clr_seq #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_clr_seq (
        .clk_main (clk_main),
        .reset    (reset),
        .en       (en),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_idx  (clr_idx)
    );

    function automatic logic in_range(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_W);
    endfunction

    function automatic logic is_zero_reg(input logic [AW-1:0] a);
        return Z0 && (a == '0);
    endfunction

    // A clear request wins the cycle; any write/read alongside it is dropped.
    assign clr_acc = en && clr_req && !busy;
    assign rd_acc  = en && re && !busy && !clr_acc;
    assign wr_ok   = en && we && !busy && !clr_acc
                  && in_range(wa) && !is_zero_reg(wa);

    function automatic logic [WIDTH-1:0] rd_word(input logic [AW-1:0] a);
        logic [WIDTH-1:0] v;
        v = '0;
        if (!in_range(a) || is_zero_reg(a)) begin
            v = '0;
        end else if (wr_ok && (wa == a)) begin
            v = wd;
        end else begin
            v = mem[a[IW-1:0]];
        end
        return v;
    endfunction

    assign nxt_a = rd_word(ra_a);
    assign nxt_b = rd_word(ra_b);

    always_ff @(posedge clk_main or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_we) begin
            mem[clr_idx] <= '0;
        end else if (wr_ok) begin
            mem[wa[IW-1:0]] <= wd;
        end
    end

    always_ff @(posedge clk_main or negedge reset) begin
        if (!reset) begin
            rd_a     <= '0;
            rd_b     <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                rd_a <= nxt_a;
                rd_b <= nxt_b;
            end
        end
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits.
REQ-002 Parameter DEPTH, default 16, number of entries; legal range 2..256.
REQ-003 Parameter AW, default 4, address width; SHALL satisfy 2^AW >= DEPTH.
REQ-004 Parameter ZERO_R0, default 0; when 1, entry 0 reads as zero and ignores writes.
REQ-005 clk_main  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset (asserted at 0).
REQ-007 en  in  1  global enable; when 0, no read, write or clear request is accepted.
REQ-008 we  in  1  write request.
REQ-009 wa  in  AW  write address.
REQ-010 wd  in  WIDTH  write data.
REQ-011 re  in  1  read request, both ports.
REQ-012 ra_a, ra_b  in  AW  read addresses, ports A and B.
REQ-013 rd_a, rd_b  out  WIDTH  registered read data.
REQ-014 rd_valid  out  1  one-cycle pulse; rd_a/rd_b hold data for the accepted read.
REQ-015 clr_req  in  1  request a full-array clear.
REQ-016 busy  out  1  high while a clear sequence is running.

Function
REQ-017 Write accepted when en=1, we=1, busy=0; mem[wa] <= wd at that edge.
REQ-018 Read accepted when en=1, re=1, busy=0; rd_a/rd_b update at that edge; rd_valid=1 for the following cycle only.
REQ-019 Read latency SHALL be exactly one cycle; back-to-back reads SHALL give one result per cycle.
REQ-020 Same-cycle write and read of the same address SHALL return wd (write-first bypass), independently per port.
REQ-021 With no accepted read, rd_a/rd_b SHALL hold their last values and rd_valid SHALL be 0.
REQ-022 ZERO_R0=1: writes to address 0 are discarded; reads of address 0 return 0, including the bypass case.
REQ-023 Address >= DEPTH: write is discarded; read returns 0.
REQ-024 FSM states: IDLE and CLEAR.
REQ-025 IDLE -> CLEAR when en=1 and clr_req=1.
REQ-026 A clear request has priority over a write or read in the same cycle; that write/read is dropped.
REQ-027 In CLEAR, busy=1 and one entry per cycle is zeroed, index 0 to DEPTH-1; the sweep takes DEPTH cycles.
REQ-028 CLEAR -> IDLE on the cycle after index DEPTH-1 is zeroed; busy=0 in that cycle.
REQ-029 In CLEAR, we, re and clr_req are ignored and rd_valid is 0.
REQ-030 In CLEAR, en=0 pauses the sweep; the index holds.

Reset
REQ-031 When reset=0: all entries 0; rd_a=0, rd_b=0, rd_valid=0, busy=0; state IDLE; clear index 0.
REQ-032 Reset during CLEAR aborts the sweep; the array is still fully zeroed.
REQ-033 The first accepted request is on the first rising edge after reset deasserts.

Structure
REQ-034 Shared package regfile_pkg holds the IDLE/CLEAR state encodings and the default WIDTH/DEPTH/AW.
REQ-035 The clear sequencer (state, index counter, busy) SHALL be sub-module regfile_clr_seq; the array, bypass and read registers stay in regfile_mp.

Verification
REQ-036 Reset, then read addresses 3 and 15 -> rd_a=0, rd_b=0, rd_valid pulses 1 cycle later.
REQ-037 Write 0xBEEF to 5, then the next cycle read ra_a=5, ra_b=5 -> both 0xBEEF after one cycle.
REQ-038 Same cycle: write 0x1234 to 7 and read ra_a=7 -> rd_a=0x1234 (bypass).
REQ-039 ZERO_R0=1: write 0xFFFF to 0, then read 0 -> 0.
REQ-040 Fill all 16 entries, pulse clr_req -> busy high exactly 16 cycles; a write during busy is ignored; afterwards all reads return 0.
REQ-041 Assert reset at sweep index 8 -> busy=0 immediately; all entries read 0 after reset release.
